// File: rtl/median_filter_pkg.sv
// Shared types for the 3x3 streaming median filter: pixel bundle and FSM states.
package median_filter_pkg;

  localparam int PKG_PIXEL_W  = 8;
  localparam int PKG_CHANNELS = 3;

  typedef logic [PKG_CHANNELS-1:0][PKG_PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/median_filter_3x3_stream_if.sv
// Pixel + valid stream bundle; the ready travels as a separate scalar on the top.
interface median_filter_3x3_stream_if;
  import median_filter_pkg::*;

  pixel_t pixel;
  logic   valid;

  modport master (output pixel, output valid);
  modport slave  (input  pixel, input  valid);

endinterface

// File: rtl/median9_sort.sv
// Combinational exact median of nine unsigned samples for a single channel.
module median9_sort #(
  parameter int PIXEL_W = 8
) (
  input  logic [8:0][PIXEL_W-1:0] i_win,
  output logic [PIXEL_W-1:0]      o_med
);

  logic [3:0] w_lt;
  logic [3:0] w_le;
  logic       w_found;

  // A sample is the median when sorted position 4 falls inside its rank span [lt, le].
  always_comb begin
    o_med   = '0;
    w_found = 1'b0;
    w_lt    = '0;
    w_le    = '0;
    for (int i = 0; i < 9; i++) begin
      w_lt = '0;
      w_le = '0;
      for (int j = 0; j < 9; j++) begin
        if (j != i) begin
          if (i_win[j] <  i_win[i]) w_lt = w_lt + 4'd1;
          if (i_win[j] <= i_win[i]) w_le = w_le + 4'd1;
        end
      end
      if (!w_found && (w_lt <= 4'd4) && (w_le >= 4'd4)) begin
        o_med   = i_win[i];
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/median_filter_3x3_stream.sv
// Streaming 3x3 per-channel median filter with two line buffers; emits the valid-only crop.
module median_filter_3x3_stream
  import median_filter_pkg::*;
#(
  parameter int MAX_IMAGE_LEN    = 1080,
  parameter int MAX_IMAGE_HEIGHT = 720,
  parameter int PIXEL_W          = PKG_PIXEL_W,
  parameter int CHANNELS         = PKG_CHANNELS
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start_i,
  input  logic [$clog2(MAX_IMAGE_LEN+1)-1:0]    image_len_i,
  input  logic [$clog2(MAX_IMAGE_HEIGHT+1)-1:0] image_height_i,
  median_filter_3x3_stream_if.slave             pixel_valid_if_i,
  output logic                                  in_ready_o,
  median_filter_3x3_stream_if.master            pixel_valid_if_o,
  input  logic                                  out_ready_i,
  output logic                                  done_o,
  output logic                                  cfg_err_o
);

  localparam int LEN_W = $clog2(MAX_IMAGE_LEN+1);
  localparam int HGT_W = $clog2(MAX_IMAGE_HEIGHT+1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_IMAGE_LEN);
  localparam logic [HGT_W-1:0] HGT_MAX = HGT_W'(MAX_IMAGE_HEIGHT);

  typedef logic [CHANNELS-1:0][PIXEL_W-1:0] pix_t;
  // Window column, index 0 = oldest row (row-2), index 2 = incoming row.
  typedef logic [2:0][CHANNELS-1:0][PIXEL_W-1:0] col_t;

  state_t           r_state, w_state_nxt;
  logic [LEN_W-1:0] r_len, r_col;
  logic [HGT_W-1:0] r_hgt, r_row;
  pix_t             r_lb1 [MAX_IMAGE_LEN];
  pix_t             r_lb2 [MAX_IMAGE_LEN];
  pix_t             w_pix_in, w_lb1_rd, w_lb2_rd, w_med;
  col_t             r_win_c0, r_win_c1, w_col_new;
  pix_t             r_pix_p1;
  logic             r_vld_p1, r_cfg_err;
  logic             w_in_ready, w_done, w_start_ok, w_accept, w_fire;
  logic             w_dims_ok, w_last_col, w_last_px, w_emit;

  assign w_pix_in   = pix_t'(pixel_valid_if_i.pixel);
  assign w_lb1_rd   = r_lb1[r_col];
  assign w_lb2_rd   = r_lb2[r_col];
  assign w_col_new  = {w_pix_in, w_lb1_rd, w_lb2_rd};
  assign w_fire     = r_vld_p1 && out_ready_i;
  assign w_accept   = w_in_ready && pixel_valid_if_i.valid;
  assign w_dims_ok  = (image_len_i >= LEN_W'(3)) && (image_len_i <= LEN_MAX) &&
                      (image_height_i >= HGT_W'(3)) && (image_height_i <= HGT_MAX);
  assign w_last_col = (r_col == r_len - 1'b1);
  assign w_last_px  = w_last_col && (r_row == r_hgt - 1'b1);
  assign w_emit     = (r_row >= HGT_W'(2)) && (r_col >= LEN_W'(2));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_done      = 1'b0;
    w_start_ok  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i && w_dims_ok) begin
          w_start_ok  = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_in_ready = !r_vld_p1 || out_ready_i;
        if (w_in_ready && pixel_valid_if_i.valid && w_last_px) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_fire) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (rst) begin
      w_in_ready = 1'b0;
      w_done     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col     <= '0;
      r_row     <= '0;
      r_vld_p1  <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= (r_state == IDLE) && start_i && !w_dims_ok;
      if (w_start_ok) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_accept) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (w_accept && w_emit) r_vld_p1 <= 1'b1;
      else if (w_fire)        r_vld_p1 <= 1'b0;
    end
  end

  // Stage p0 -> p1: line buffers, window shift and registered median.
  always_ff @(posedge clk) begin
    if (w_start_ok) begin
      r_len <= image_len_i;
      r_hgt <= image_height_i;
    end
    if (w_accept) begin
      r_lb1[r_col] <= w_pix_in;
      r_lb2[r_col] <= w_lb1_rd;
      r_win_c0     <= r_win_c1;
      r_win_c1     <= w_col_new;
    end
    if (w_accept && w_emit) r_pix_p1 <= w_med;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [8:0][PIXEL_W-1:0] w_samp;
    assign w_samp = {w_col_new[2][c], w_col_new[1][c], w_col_new[0][c],
                     r_win_c1[2][c],  r_win_c1[1][c],  r_win_c1[0][c],
                     r_win_c0[2][c],  r_win_c0[1][c],  r_win_c0[0][c]};
    median9_sort #(.PIXEL_W(PIXEL_W)) u_med (
      .i_win (w_samp),
      .o_med (w_med[c])
    );
  end

  assign pixel_valid_if_o.pixel = pixel_t'(r_pix_p1);
  assign pixel_valid_if_o.valid = r_vld_p1;
  assign in_ready_o             = w_in_ready;
  assign done_o                 = w_done;
  assign cfg_err_o              = r_cfg_err;

endmodule
